// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter: round-robin arbiter/sequencer sharing one square-root engine
// among NUM_REQ requesters. Issues one job at a time, waits for the engine's
// done pulse (bounded by TIMEOUT cycles) and returns result/residue or an error.
module sqrt_arbiter #(
  parameter int WORD_LENGTH = 16,
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT     = 15
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ*(WORD_LENGTH/2)-1:0]    req_data,
  output logic [NUM_REQ-1:0]                    req_ready,
  output logic [NUM_REQ-1:0]                    rsp_valid,
  output logic [WORD_LENGTH-1:0]                rsp_result,
  output logic [WORD_LENGTH-1:0]                rsp_residue,
  output logic                                  rsp_error,
  output logic                                  busy,
  output logic                                  eng_start,
  output logic [WORD_LENGTH/2-1:0]              eng_operand,
  input  logic                                  eng_done,
  input  logic [WORD_LENGTH-1:0]                eng_result,
  input  logic [WORD_LENGTH-1:0]                eng_residue
);

  localparam int OP_W  = WORD_LENGTH / 2;
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [PTR_W-1:0]         ptr_q, ptr_d;
  logic [PTR_W-1:0]         grant_q, grant_d;
  logic [TMR_W-1:0]         timer_q, timer_d;

  logic [NUM_REQ-1:0]       req_ready_d, rsp_valid_d;
  logic [WORD_LENGTH-1:0]   rsp_result_d, rsp_residue_d;
  logic                     rsp_error_d, busy_d, eng_start_d;
  logic [OP_W-1:0]          eng_operand_d;

  logic                     found;
  logic [PTR_W-1:0]         pick;
  logic [OP_W-1:0]          pick_op;
  int                       idx;

  // Round-robin search starting at ptr, wrapping modulo NUM_REQ.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    found   = 1'b0;
    pick    = '0;
    pick_op = '0;
    idx     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr_q) + i) % NUM_REQ;
      if (!found && req_valid[PTR_W'(idx)]) begin
        found = 1'b1;
        pick  = PTR_W'(idx);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (PTR_W'(i) == pick) pick_op = req_data[i*OP_W +: OP_W];
    end
  end

  // Next-state logic; registered outputs are computed for the state being entered.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    timer_d       = timer_q;
    req_ready_d   = '0;
    rsp_valid_d   = '0;
    eng_start_d   = 1'b0;
    eng_operand_d = eng_operand;
    rsp_result_d  = rsp_result;
    rsp_residue_d = rsp_residue;
    rsp_error_d   = rsp_error;

    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d            = pick;
          eng_operand_d      = pick_op;
          req_ready_d[pick]  = 1'b1;
          eng_start_d        = 1'b1;
          state_d            = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        // done has priority over the timeout when both land in the same cycle
        if (eng_done) begin
          rsp_result_d         = eng_result;
          rsp_residue_d        = eng_residue;
          rsp_error_d          = 1'b0;
          rsp_valid_d[grant_q] = 1'b1;
          state_d              = S_RESPOND;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          rsp_result_d         = '0;
          rsp_residue_d        = '0;
          rsp_error_d          = 1'b1;
          rsp_valid_d[grant_q] = 1'b1;
          state_d              = S_RESPOND;
        end
      end
      S_RESPOND: begin
        ptr_d   = (grant_q == PTR_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset clears everything and drops any job.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      timer_q     <= '0;
      req_ready   <= '0;
      rsp_valid   <= '0;
      rsp_result  <= '0;
      rsp_residue <= '0;
      rsp_error   <= 1'b0;
      busy        <= 1'b0;
      eng_start   <= 1'b0;
      eng_operand <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      timer_q     <= timer_d;
      req_ready   <= req_ready_d;
      rsp_valid   <= rsp_valid_d;
      rsp_result  <= rsp_result_d;
      rsp_residue <= rsp_residue_d;
      rsp_error   <= rsp_error_d;
      busy        <= busy_d;
      eng_start   <= eng_start_d;
      eng_operand <= eng_operand_d;
    end
  end

endmodule

// File: tb/tb_sqrt_arbiter.sv
// tb_sqrt_arbiter: directed bench for sqrt_arbiter with a scripted engine.
module tb_sqrt_arbiter;

  localparam int W       = 16;
  localparam int OP_W    = W / 2;
  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 15;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*OP_W-1:0] req_data;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ-1:0]      rsp_valid;
  logic [W-1:0]            rsp_result;
  logic [W-1:0]            rsp_residue;
  logic                    rsp_error;
  logic                    busy;
  logic                    eng_start;
  logic [OP_W-1:0]         eng_operand;
  logic                    eng_done;
  logic [W-1:0]            eng_result;
  logic [W-1:0]            eng_residue;

  int n_tests = 0;
  int n_fail  = 0;

  sqrt_arbiter #(.WORD_LENGTH(W), .NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_residue(rsp_residue),
    .rsp_error  (rsp_error),
    .busy       (busy),
    .eng_start  (eng_start),
    .eng_operand(eng_operand),
    .eng_done   (eng_done),
    .eng_result (eng_result),
    .eng_residue(eng_residue)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [OP_W-1:0] op);
    req_valid[i]             = v;
    req_data[i*OP_W +: OP_W] = op;
  endtask

  // One job from grant edge to the following IDLE cycle. done_cyc is the cycle
  // (grant edge = edge 0) in which the engine pulses done; -1 means never.
  task automatic run_job(input string tag, input int g, input logic [OP_W-1:0] op,
                         input int done_cyc, input logic [W-1:0] res,
                         input logic [W-1:0] resid, input bit drop);
    bit                 err;
    int                 exp_cyc;
    int                 cyc;
    logic [NUM_REQ-1:0] seen;
    err     = (done_cyc < 2) || (done_cyc > TIMEOUT + 1);
    exp_cyc = err ? TIMEOUT + 2 : done_cyc + 1;

    step();
    check({tag, ".ready"},   32'(req_ready), 32'(1 << g));
    check({tag, ".start"},   32'(eng_start), 32'd1);
    check({tag, ".operand"}, 32'(eng_operand), 32'(op));
    check({tag, ".busy"},    32'(busy), 32'd1);
    if (drop) req_valid[g] = 1'b0;

    cyc  = 1;
    seen = '0;
    while (cyc < TIMEOUT + 4 && seen == '0) begin
      if (cyc == done_cyc) begin
        eng_done = 1'b1; eng_result = res; eng_residue = resid;
      end else begin
        eng_done = 1'b0; eng_result = 16'hDEAD; eng_residue = 16'hDEAD;
      end
      step();
      cyc++;
      seen = rsp_valid;
      if (cyc == 2) begin
        check({tag, ".start_drop"}, 32'(eng_start), 32'd0);
        check({tag, ".ready_drop"}, 32'(req_ready), 32'd0);
      end
    end
    eng_done = 1'b0;

    check({tag, ".rsp_cycle"}, 32'(cyc), 32'(exp_cyc));
    check({tag, ".rsp_valid"}, 32'(seen), 32'(1 << g));
    check({tag, ".result"},    32'(rsp_result), err ? 32'd0 : 32'(res));
    check({tag, ".residue"},   32'(rsp_residue), err ? 32'd0 : 32'(resid));
    check({tag, ".error"},     32'(rsp_error), 32'(err));

    step();
    check({tag, ".idle_busy"}, 32'(busy), 32'd0);
    check({tag, ".rsp_pulse"}, 32'(rsp_valid), 32'd0);
    check({tag, ".hold"},      32'(rsp_result), err ? 32'd0 : 32'(res));
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
  endtask

  initial begin
    reset       = 1'b0;
    req_valid   = '0;
    req_data    = '0;
    eng_done    = 1'b0;
    eng_result  = '0;
    eng_residue = '0;

    // Reset state
    repeat (2) step();
    check("reset.outputs", {rsp_valid, req_ready, 7'(rsp_error), busy, eng_start, 7'd0},
          32'd0);
    check("reset.result",  32'({rsp_result, rsp_residue}), 32'd0);
    check("reset.operand", 32'(eng_operand), 32'd0);
    reset = 1'b1;
    step();

    // Single request: 81 -> 9 / 0, response in cycle 7
    set_req(0, 1'b1, 8'h51);
    run_job("single", 0, 8'h51, 6, 16'd9, 16'd0, 1'b1);

    // Fairness: everyone requests continuously from ptr = 0
    apply_reset();
    set_req(0, 1'b1, 8'h10);
    set_req(1, 1'b1, 8'h19);
    set_req(2, 1'b1, 8'h0A);
    set_req(3, 1'b1, 8'h64);
    run_job("fair0", 0, 8'h10, 2, 16'd4,  16'd0, 1'b0);
    run_job("fair1", 1, 8'h19, 3, 16'd5,  16'd0, 1'b0);
    run_job("fair2", 2, 8'h0A, 4, 16'd3,  16'd1, 1'b0);
    run_job("fair3", 3, 8'h64, 5, 16'd10, 16'd0, 1'b0);
    run_job("fair4", 0, 8'h10, 2, 16'd4,  16'd0, 1'b0);
    req_valid = '0;
    step();
    check("fair.quiet", 32'(busy), 32'd0);

    // Timeout on requester 1 (ptr = 1), then a late done is ignored
    set_req(1, 1'b1, 8'h30);
    run_job("timeout", 1, 8'h30, -1, 16'd0, 16'd0, 1'b1);
    eng_done = 1'b1; eng_result = 16'hBEEF; eng_residue = 16'hBEEF;
    step();
    eng_done = 1'b0;
    step();
    check("late.busy",  32'(busy), 32'd0);
    check("late.rsp",   32'(rsp_valid), 32'd0);
    check("late.start", 32'(eng_start), 32'd0);
    check("late.hold",  32'({rsp_result, rsp_residue}), 32'd0);
    check("late.error", 32'(rsp_error), 32'd1);

    // Tie at the limit: done exactly when timer reaches TIMEOUT-1 (cycle 16)
    set_req(2, 1'b1, 8'hC8);
    run_job("tie", 2, 8'hC8, TIMEOUT + 1, 16'd14, 16'd4, 1'b1);

    // Pointer wrap: serve 3, then 0 and 3 together -> 0 first
    set_req(3, 1'b1, 8'h02);
    run_job("wrap3", 3, 8'h02, 2, 16'd1, 16'd1, 1'b1);
    set_req(0, 1'b1, 8'h90);
    set_req(3, 1'b1, 8'h05);
    run_job("wrap0",  0, 8'h90, 3, 16'd12, 16'd0, 1'b1);
    run_job("wrap3b", 3, 8'h05, 2, 16'd2,  16'd1, 1'b1);

    // Reset mid-job: bring ptr to 3, start job 3 with 2 also pending
    set_req(2, 1'b1, 8'h31);
    run_job("pre2", 2, 8'h31, 2, 16'd7, 16'd0, 1'b1);
    set_req(3, 1'b1, 8'h40);
    set_req(2, 1'b1, 8'h31);
    step();
    check("mid.grant", 32'(req_ready), 32'h8);
    repeat (2) step();
    check("mid.in_wait", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("mid.busy",  32'(busy), 32'd0);
    check("mid.rsp",   32'(rsp_valid), 32'd0);
    check("mid.start", 32'(eng_start), 32'd0);
    check("mid.out",   32'({rsp_result, rsp_residue}), 32'd0);
    repeat (2) step();
    reset = 1'b1;
    // ptr = 0 after reset, so 2 wins over 3
    run_job("post2", 2, 8'h31, 3, 16'd7, 16'd0, 1'b1);
    run_job("post3", 3, 8'h40, 2, 16'd8, 16'd0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sqrt_arbiter.md
# sqrt_arbiter

Round-robin arbiter and sequencer that shares one square-root engine among `NUM_REQ` requesters. For each granted request it latches the operand, pulses the engine start and waits for the engine done. It then returns the result and residue to the winning requester, or returns an error if the engine exceeds a cycle budget. It sits between the client ports and the single square-root datapath instance, and is the only block that drives that datapath's start and operand.

## Interface
- `WORD_LENGTH`, 16, result and residue width; operand width is `WORD_LENGTH/2`.
- `NUM_REQ`, 4, number of requesters; must be at least 2.
- `TIMEOUT`, 15, maximum WAIT cycles before the arbiter aborts; must be at least 1.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  `NUM_REQ`  request i pending; held high until `req_ready[i]` is seen.
- `req_data`  in  `NUM_REQ*WORD_LENGTH/2`  operands, packed; requester i uses bits `[i*WORD_LENGTH/2 +: WORD_LENGTH/2]`.
- `req_ready`  out  `NUM_REQ`  one-hot, 1-cycle accept pulse.
- `rsp_valid`  out  `NUM_REQ`  one-hot, 1-cycle response pulse.
- `rsp_result`  out  `WORD_LENGTH`  square root of the last completed request.
- `rsp_residue`  out  `WORD_LENGTH`  residue of the last completed request.
- `rsp_error`  out  1  set when the last request timed out.
- `busy`  out  1  high whenever the state is not IDLE.
- `eng_start`  out  1  1-cycle start pulse to the engine.
- `eng_operand`  out  `WORD_LENGTH/2`  operand presented to the engine; held stable from ISSUE until the next grant.
- `eng_done`  in  1  engine completion pulse.
- `eng_result`  in  `WORD_LENGTH`  engine root; valid while `eng_done` is high.
- `eng_residue`  in  `WORD_LENGTH`  engine residue; valid while `eng_done` is high.

## Operation
- **Outputs:** all outputs are registered. Reset value of every output is 0. Reset also sets the state to IDLE, the priority pointer `ptr` to 0 and the timer to 0.
- **FSM states:** IDLE, ISSUE, WAIT, RESPOND.
- **IDLE:**
  - If any `req_valid` is high, grant the first asserted index found by searching `ptr`, `ptr+1`, … wrapping modulo `NUM_REQ`.
  - On that edge, latch the grant index and the requester's operand, then go to ISSUE.
  - With no request pending, remain in IDLE.
- **ISSUE (1 cycle):** `req_ready[g]=1`, `eng_start=1`, `eng_operand` = latched operand. Clear the timer and go to WAIT.
- **WAIT:**
  - The timer increments every cycle.
  - On `eng_done`: capture `eng_result` and `eng_residue`, set error to 0, go to RESPOND.
  - Else, when the timer reaches `TIMEOUT-1`: set result and residue to 0, set error to 1, go to RESPOND.
  - If `eng_done` arrives in the same cycle the timer reaches its limit, `eng_done` wins and no error is flagged.
- **RESPOND (1 cycle):**
  - `rsp_valid[g]=1`.
  - Set `ptr <= (g+1) mod NUM_REQ`.
  - Go to IDLE.
- **Response hold:** `rsp_result`, `rsp_residue` and `rsp_error` hold their values until the next RESPOND.
- **Ignored done:** `eng_done` is ignored in IDLE, ISSUE and RESPOND. A late done from a timed-out job is therefore discarded.
- **Other requesters:** `req_valid` from non-granted requesters is ignored while busy. Those requests stay pending and are arbitrated at the next IDLE.
- **Widths:** the timer is `$clog2(TIMEOUT+1)` bits. `ptr` and the grant index are `$clog2(NUM_REQ)` bits. No arithmetic is applied to data; values pass through unchanged.
- **Reset mid-operation:** asserting `reset` in any state immediately forces IDLE and all-zero outputs. Any in-flight job is lost without a response.

## Timing
- Request seen high before edge 0 → ISSUE in cycle 1 (`req_ready`, `eng_start`) → first WAIT cycle is cycle 2.
- An `eng_done` in WAIT cycle k gives `rsp_valid` in cycle k+1.
- Minimum request-to-response latency is 3 cycles (done in cycle 2, response in cycle 3).
- A timeout response appears `TIMEOUT+2` cycles after the grant edge.
- Back-to-back: RESPOND → IDLE → next grant, so there are at least 2 cycles between consecutive `eng_start` pulses plus the engine latency.
- Requester contract: hold `req_data` until `req_ready` is observed, and drop `req_valid` in the cycle after `req_ready`. If `req_valid` stays high, it is a new request.

## Test plan
- **Single request:** reset, requester 0 sends 0x51 (81), engine answers root 9 / residue 0 after 4 WAIT cycles → `req_ready[0]` in cycle 1, `eng_start` in cycle 1, `rsp_valid[0]` in cycle 7 with 9/0, `rsp_error=0`.
- **Fairness:** all 4 requesters hold `req_valid` continuously → grant order 0, 1, 2, 3, 0; each grant is followed by exactly one matching `rsp_valid` bit.
- **Timeout:** with `TIMEOUT=15`, the engine never asserts done → `rsp_valid[g]` exactly 17 cycles after the grant edge with result 0, residue 0, `rsp_error=1`. A late `eng_done` pulse afterwards is ignored: no response and no state change.
- **Tie at the limit:** `eng_done` in the same cycle the timer reaches 14 → result captured, `rsp_error=0`.
- **Reset mid-job:** `reset` low during WAIT → `busy`, `rsp_valid` and `eng_start` drop to 0 immediately and `ptr=0`. After release, a pending request on requester 2 is granted with a clean response.
- **Pointer wrap:** requester 3 is served, then requesters 0 and 3 request together → requester 0 is granted first.
